// File: rtl/vend_pkg.sv
// Shared state type, coin values and coin-priority helper for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, VEND, CHANGE, REFUND} state_t;

  localparam logic [2:0] V5  = 3'd1;
  localparam logic [2:0] V10 = 3'd2;
  localparam logic [2:0] V20 = 3'd4;

  // Value of the highest-priority coin pressed this edge (c5 > c10 > c20), 0 when none.
  function automatic logic [2:0] coin_value(input logic p5, input logic p10, input logic p20);
    logic [2:0] v;
    if (p5)       v = V5;
    else if (p10) v = V10;
    else if (p20) v = V20;
    else          v = 3'd0;
    return v;
  endfunction

endpackage

// File: rtl/vend_press_det.sv
// Per-button press detector: optional 2-flop synchronizer, then released-to-pressed edge detect.
// The synchronizer is built only when VEND_SYNC_EN is defined.
module vend_press_det (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic w_level;
  logic r_hist;

`ifdef VEND_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_level = r_sync2;
`else
  assign w_level = i_btn;
`endif

  // Buttons are active-low, so history resets to the released level.
  always_ff @(posedge clk) begin
    if (rst) r_hist <= 1'b1;
    else     r_hist <= w_level;
  end

  assign o_press = r_hist & ~w_level;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Coin-credit vending controller: credits 5/10/20 presses, dispenses at PRICE, paces change and refunds.
// Define VEND_SYNC_EN to put a 2-flop synchronizer in front of every button (+2 cycles latency).
module vend_credit_ctrl #(
  parameter int PRICE           = 9,
  parameter int CREDIT_W        = 6,
  parameter int MAX_CREDIT      = 63,
  parameter int DISPENSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c5,
  input  logic                c10,
  input  logic                c20,
  input  logic                cancel,
  output logic                dispense,
  output logic                change5,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] led
);

  import vend_pkg::*;

  localparam int CNT_W = $clog2(DISPENSE_CYCLES + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W + 1)'(MAX_CREDIT);

  if ((PRICE + 3 > MAX_CREDIT) || (MAX_CREDIT > (2 ** CREDIT_W) - 1) || (DISPENSE_CYCLES < 1))
  begin : g_paramCheck
    $error("vend_credit_ctrl: illegal PRICE/MAX_CREDIT/CREDIT_W/DISPENSE_CYCLES combination");
  end

  logic w_press5, w_press10, w_press20, w_pressCancel;
  logic w_coinAny, w_multi, w_overflow;
  logic [2:0] w_coinVal;
  logic [CREDIT_W:0] w_sum;

  state_t r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CNT_W-1:0] r_cnt;
  logic r_dispense, r_change5, r_reject, r_busy;

  vend_press_det u_det5      (.clk(clk), .rst(rst), .i_btn(c5),     .o_press(w_press5));
  vend_press_det u_det10     (.clk(clk), .rst(rst), .i_btn(c10),    .o_press(w_press10));
  vend_press_det u_det20     (.clk(clk), .rst(rst), .i_btn(c20),    .o_press(w_press20));
  vend_press_det u_detCancel (.clk(clk), .rst(rst), .i_btn(cancel), .o_press(w_pressCancel));

  assign w_coinAny = w_press5 | w_press10 | w_press20;
  assign w_multi   = (w_press5 & w_press10) | (w_press5 & w_press20) | (w_press10 & w_press20);
  assign w_coinVal = coin_value(w_press5, w_press10, w_press20);
  // One extra bit so an over-limit sum is caught instead of wrapping.
  assign w_sum      = {1'b0, r_credit} + (CREDIT_W + 1)'(w_coinVal);
  assign w_overflow = w_sum > MAX_X;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_credit   <= '0;
      r_cnt      <= '0;
      r_dispense <= 1'b0;
      r_change5  <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_reject  <= 1'b0;
      r_change5 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pressCancel && (r_credit != '0)) begin
            r_state  <= REFUND;
            r_busy   <= 1'b1;
            r_reject <= w_coinAny;
          end else if (w_coinAny) begin
            if (w_overflow) begin
              r_reject <= 1'b1;
            end else begin
              r_credit <= w_sum[CREDIT_W-1:0];
              r_reject <= w_multi;
              if (w_sum >= PRICE_X) begin
                r_state <= VEND;
                r_busy  <= 1'b1;
              end
            end
          end
        end
        // First VEND cycle still shows the full credit; the price is taken as dispense rises.
        VEND: begin
          r_reject <= w_coinAny;
          if (!r_dispense) begin
            r_credit   <= r_credit - PRICE_C;
            r_dispense <= 1'b1;
            r_cnt      <= CNT_W'(1);
          end else if (r_cnt == CNT_W'(DISPENSE_CYCLES)) begin
            r_dispense <= 1'b0;
            r_cnt      <= '0;
            if (r_credit != '0) begin
              r_state <= CHANGE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // A pulse cycle is always followed by a gap; leave only from a gap with nothing left.
        CHANGE, REFUND: begin
          r_reject <= w_coinAny;
          if (!r_change5) begin
            if (r_credit == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_change5 <= 1'b1;
              r_credit  <= r_credit - CREDIT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign dispense    = r_dispense;
  assign change5     = r_change5;
  assign coin_reject = r_reject;
  assign busy        = r_busy;
  assign credit      = r_credit;
  assign led         = ~r_credit;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios with literal expectations plus
// randomized button traffic, all checked every cycle against a schedule-based behavioural model.
module tb_vend_credit_ctrl;

  localparam int PRICE      = 9;
  localparam int CREDIT_W   = 6;
  localparam int MAX_CREDIT = 12;
  localparam int DISP       = 4;
`ifdef VEND_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c5 = 1'b1, c10 = 1'b1, c20 = 1'b1, cancel = 1'b1;
  logic dispense, change5, coin_reject, busy;
  logic [CREDIT_W-1:0] credit, led;

  vend_credit_ctrl #(
    .PRICE(PRICE), .CREDIT_W(CREDIT_W), .MAX_CREDIT(MAX_CREDIT), .DISPENSE_CYCLES(DISP)
  ) dut (
    .clk(clk), .rst(rst), .c5(c5), .c10(c10), .c20(c20), .cancel(cancel),
    .dispense(dispense), .change5(change5), .coin_reject(coin_reject), .busy(busy),
    .credit(credit), .led(led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: while the machine is busy its outputs follow a precomputed per-cycle
  // schedule (dispense burst, then alternating pulse/gap returns); while idle it does coin arithmetic.
  typedef struct {
    logic disp;
    logic chg;
    logic busy;
    int   credit;
  } rec_t;

  rec_t sched[$];
  bit   mValid = 1'b0;
  int   mCredit = 0;
  logic mDisp = 1'b0, mChg = 1'b0, mRej = 1'b0, mBusy = 1'b0;
  logic [3:0] mPrev = 4'hF, mS1 = 4'hF, mS2 = 4'hF;

  int wDisp, wChg, wRej, wMax;

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pushRec(input logic d, input logic c, input logic b, input int cr);
    rec_t r;
    r.disp = d; r.chg = c; r.busy = b; r.credit = cr;
    sched.push_back(r);
  endtask

  task automatic pushReturn(input int n);
    for (int k = n - 1; k >= 0; k--) begin
      pushRec(1'b0, 1'b1, 1'b1, k);
      pushRec(1'b0, 1'b0, 1'b1, k);
    end
    pushRec(1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic modelStep();
    logic [3:0] raw, eff, pr;
    int nCoins, v, rem;
    rec_t r;
    raw = {cancel, c20, c10, c5};
    if (rst) begin
      sched.delete();
      mCredit = 0; mDisp = 1'b0; mChg = 1'b0; mRej = 1'b0; mBusy = 1'b0;
      mPrev = 4'hF; mS1 = 4'hF; mS2 = 4'hF;
      mValid = 1'b1;
      return;
    end
`ifdef VEND_SYNC_EN
    eff = mS2; mS2 = mS1; mS1 = raw;
`else
    eff = raw;
`endif
    pr = mPrev & ~eff;
    mPrev = eff;
    nCoins = int'(pr[0]) + int'(pr[1]) + int'(pr[2]);
    mRej = 1'b0;
    if (mBusy) begin
      mRej = (nCoins > 0);
      if (sched.size() == 0) begin
        checkValue("modelSchedule", 0, 1);
        mBusy = 1'b0;
      end else begin
        r = sched.pop_front();
        mDisp = r.disp; mChg = r.chg; mBusy = r.busy; mCredit = r.credit;
      end
    end else if (pr[3] && mCredit > 0) begin
      mRej = (nCoins > 0);
      mBusy = 1'b1;
      pushReturn(mCredit);
    end else if (nCoins > 0) begin
      v = pr[0] ? 1 : (pr[1] ? 2 : 4);
      if (mCredit + v > MAX_CREDIT) begin
        mRej = 1'b1;
      end else begin
        mCredit = mCredit + v;
        mRej = (nCoins > 1);
        if (mCredit >= PRICE) begin
          mBusy = 1'b1;
          rem = mCredit - PRICE;
          for (int i = 0; i < DISP; i++) pushRec(1'b1, 1'b0, 1'b1, rem);
          if (rem > 0) begin
            pushRec(1'b0, 1'b0, 1'b1, rem);
            pushReturn(rem);
          end else begin
            pushRec(1'b0, 1'b0, 1'b0, 0);
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("credit", int'(credit), mCredit);
    checkValue("led", int'(led), (~mCredit) & ((1 << CREDIT_W) - 1));
    checkValue("dispense", int'(dispense), int'(mDisp));
    checkValue("change5", int'(change5), int'(mChg));
    checkValue("coin_reject", int'(coin_reject), int'(mRej));
    checkValue("busy", int'(busy), int'(mBusy));
  endtask

  always @(posedge clk) begin
    modelStep();
    #1;
    if (mValid) checkOutput();
  end

  // mask bits: 0=c5 1=c10 2=c20 3=cancel; pressed for one cycle, then n cycles observed
  task automatic applyStimulus(input logic [3:0] mask, input int n);
    wDisp = 0; wChg = 0; wRej = 0; wMax = 0;
    @(negedge clk);
    {cancel, c20, c10, c5} = ~mask;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) {cancel, c20, c10, c5} = 4'hF;
      wDisp += int'(dispense);
      wChg  += int'(change5);
      wRej  += int'(coin_reject);
      if (int'(credit) > wMax) wMax = int'(credit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, seen;
    bit found;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkValue("rstCredit", int'(credit), 0);
    checkValue("rstLed", int'(led), 63);
    checkValue("rstDispense", int'(dispense), 0);
    checkValue("rstBusy", int'(busy), 0);
    rst = 1'b0;

    // Exact payment 20+20+5
    applyStimulus(4'b0100, 6);
    checkValue("exactCredit4", int'(credit), 4);
    applyStimulus(4'b0100, 6);
    checkValue("exactCredit8", int'(credit), 8);
    applyStimulus(4'b0001, 20);
    checkValue("exactPeak", wMax, 9);
    checkValue("exactDispCycles", wDisp, 4);
    checkValue("exactChange", wChg, 0);
    checkValue("exactFinalCredit", int'(credit), 0);

    // Overpay to the MAX_CREDIT boundary: 8 + 4 = 12 accepted, 3 coins back
    applyStimulus(4'b0100, 6);
    applyStimulus(4'b0100, 6);
    applyStimulus(4'b0100, 40);
    checkValue("overPeak", wMax, 12);
    checkValue("overDispCycles", wDisp, 4);
    checkValue("overChange", wChg, 3);
    checkValue("overFinalCredit", int'(credit), 0);
    checkValue("overBusy", int'(busy), 0);

    // Cancel with a simultaneous coin: refund, coin rejected
    applyStimulus(4'b0100, 6);
    applyStimulus(4'b0010, 6);
    checkValue("refundCredit6", int'(credit), 6);
    applyStimulus(4'b1001, 30);
    checkValue("refundReject", wRej, 1);
    checkValue("refundChange", wChg, 6);
    checkValue("refundDisp", wDisp, 0);
    checkValue("refundFinal", int'(credit), 0);

    // c5 and c10 together: c5 wins, one reject pulse
    applyStimulus(4'b0011, 8);
    checkValue("collideCredit", int'(credit), 1);
    checkValue("collideReject", wRej, 1);
    applyStimulus(4'b1000, 12);
    checkValue("collideRefund", wChg, 1);

    // c10 while vending is rejected
    applyStimulus(4'b0100, 6);
    applyStimulus(4'b0100, 6);
    applyStimulus(4'b0001, 3);
    applyStimulus(4'b0010, 20);
    checkValue("busyReject", wRej, 1);
    checkValue("busyFinalCredit", int'(credit), 0);

    // Held c5 counts once
    wRej = 0;
    @(negedge clk);
    c5 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      wRej += int'(coin_reject);
    end
    c5 = 1'b1;
    repeat (5) @(negedge clk);
    checkValue("heldCredit", int'(credit), 1);
    checkValue("heldReject", wRej, 0);

    // Press-to-credit latency
    @(negedge clk);
    c5 = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n++;
      if (n == 1) c5 = 1'b1;
      if (int'(credit) != 1) break;
    end
    checkValue("latency", n, LAT);
    applyStimulus(4'b1000, 12);
    checkValue("latencyRefund", int'(credit), 0);

    // Reset during the second change pulse of a 3-coin return
    applyStimulus(4'b0100, 6);
    applyStimulus(4'b0100, 6);
    applyStimulus(4'b0100, 1);
    found = 1'b0;
    seen = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (change5) begin
        seen++;
        if (seen == 2) found = 1'b1;
      end
    end
    checkValue("midSecondPulse", int'(found), 1);
    if (found) begin
      checkValue("midCreditBefore", int'(credit), 1);
      rst = 1'b1;
      @(negedge clk);
      checkValue("midRstCredit", int'(credit), 0);
      checkValue("midRstChange", int'(change5), 0);
      checkValue("midRstBusy", int'(busy), 0);
      rst = 1'b0;
    end
    repeat (4) @(negedge clk);

    // Randomized traffic, occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 499) == 0);
      c5     = ($urandom_range(0, 5) != 0);
      c10    = ($urandom_range(0, 5) != 0);
      c20    = ($urandom_range(0, 5) != 0);
      cancel = ($urandom_range(0, 19) != 0);
    end
    @(negedge clk);
    rst = 1'b0;
    {cancel, c20, c10, c5} = 4'hF;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
